// File: rtl/seq_divider_8by4.sv
// rtl/seq_divider_8by4.sv - sequential restoring divider, one quotient bit per clock
// Optional seven-segment result outputs are enabled by defining SEQ_DIVIDER_HEX_OUT_EN.

`ifdef SEQ_DIVIDER_HEX_OUT_EN
module binary4todecimal7decoder (
    input  logic [3:0] bin,
    output logic [6:0] seg
);
    // Active-low segments ordered gfedcba; nibbles above 9 show hex glyphs.
    always_comb begin
        seg = 7'b1111111;
        case (bin)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule
`endif

module seq_divider_8by4 #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
`ifdef SEQ_DIVIDER_HEX_OUT_EN
    output logic [6:0]            HEXQ0,
    output logic [6:0]            HEXQ1,
    output logic [6:0]            HEXR,
`endif
    output logic                  div_by_zero
);
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [DIVISOR_W:0]    pr;
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dvs;

    logic [DIVISOR_W:0]    pr_shift;
    logic [DIVISOR_W:0]    pr_next;
    logic                  qbit;
    logic [DIVIDEND_W-1:0] dvd_next;

    // dvd doubles as the quotient register: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    always_comb begin
        pr_shift = {pr[DIVISOR_W-1:0], dvd[DIVIDEND_W-1]};
        qbit     = (pr_shift >= {1'b0, dvs});
        pr_next  = qbit ? (pr_shift - {1'b0, dvs}) : pr_shift;
        dvd_next = {dvd[DIVIDEND_W-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            pr          <= '0;
            dvd         <= '0;
            dvs         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        pr    <= '0;
                        count <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    pr    <= pr_next;
                    dvd   <= dvd_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= dvd_next;
                        remainder   <= pr_next[DIVISOR_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_DIVIDER_HEX_OUT_EN
    binary4todecimal7decoder u_hex_q0 (.bin(quotient[3:0]), .seg(HEXQ0));
    binary4todecimal7decoder u_hex_q1 (.bin(quotient[7:4]), .seg(HEXQ1));
    binary4todecimal7decoder u_hex_r  (.bin(remainder[3:0]), .seg(HEXR));
`endif

endmodule

// File: tb/tb_seq_divider_8by4.sv
// tb/tb_seq_divider_8by4.sv - directed and sweep bench for seq_divider_8by4

module tb_seq_divider_8by4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
`ifdef SEQ_DIVIDER_HEX_OUT_EN
    logic [6:0] hexq0, hexq1, hexr;
`endif

    int checks = 0;
    int errors = 0;

    seq_divider_8by4 dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
`ifdef SEQ_DIVIDER_HEX_OUT_EN
        .HEXQ0(hexq0),
        .HEXQ1(hexq1),
        .HEXR(hexr),
`endif
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue a start; returns 1 time unit after the accepting edge with operands scrambled.
    task automatic begin_div(input logic [7:0] n, input logic [3:0] d);
        @(negedge clk);
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busyc);
        lat   = 0;
        busyc = 0;
        while (!done && lat < 20) begin
            check("busy_done_excl", 32'(busy & done), 0);
            if (busy) busyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_seen", 32'(done), 1);
        check("busy_at_done", 32'(busy), 0);
    endtask

    task automatic check_result(input string tag, input int q, input int r, input int z);
        check({tag, "_q"}, 32'(quotient), q);
        check({tag, "_r"}, 32'(remainder), r);
        check({tag, "_dbz"}, 32'(div_by_zero), z);
    endtask

    initial begin
        int lat, busyc, lat2;

        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        begin_div(8'd200, 4'd13);
        wait_done(lat, busyc);
        check("t200_lat", lat, 8);
        check("t200_busy", busyc, 8);
        check_result("t200", 15, 5, 0);
        @(posedge clk); #1;
        check("t200_pulse", 32'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        check_result("t200_hold", 15, 5, 0);

        begin_div(8'd255, 4'd1);
        wait_done(lat, busyc);
        check("t255_lat", lat, 8);
        check_result("t255", 255, 0, 0);

        begin_div(8'd7, 4'd9);
        wait_done(lat, busyc);
        check_result("t7", 0, 7, 0);

        begin_div(8'd100, 4'd0);
        wait_done(lat, busyc);
        check("dbz_lat", lat, 0);
        check("dbz_busy", busyc, 0);
        check_result("dbz", 255, 0, 1);

        // start during RUN must not disturb the running division
        begin_div(8'd200, 4'd13);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd50; divisor = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, busyc);
        check("ign_lat", lat, 4);
        check_result("ign", 15, 5, 0);

        // abort with reset mid-RUN
        begin_div(8'd200, 4'd13);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check_result("abort", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        begin_div(8'd255, 4'd1);
        wait_done(lat, busyc);
        check("post_abort_lat", lat, 8);
        check_result("post_abort", 255, 0, 0);

        // start held through DONE: back-to-back acceptance
        @(negedge clk);
        dividend = 8'd200; divisor = 4'd13; start = 1'b1;
        @(posedge clk);
        #1;
        dividend = 8'd255; divisor = 4'd1;
        wait_done(lat, busyc);
        check("b2b_lat1", lat, 8);
        check_result("b2b1", 15, 5, 0);
        @(posedge clk); #1;
        check("b2b_rerun_done", 32'(done), 0);
        check("b2b_rerun_busy", 32'(busy), 1);
        wait_done(lat2, busyc);
        start = 1'b0;
        check("b2b_gap", lat2 + 1, 9);
        check_result("b2b2", 255, 0, 0);
        @(posedge clk); #1;
        check("b2b_end_done", 32'(done), 0);

        // all operand pairs against the division invariant
        for (int n = 0; n < 256; n++) begin
            for (int d = 0; d < 16; d++) begin
                begin_div(8'(n), 4'(d));
                wait_done(lat, busyc);
                if (d != 0) begin
                    check("sweep_inv", 32'(quotient) * 32'(d) + 32'(remainder), n);
                    check("sweep_rlt", 32'(remainder < 4'(d)), 1);
                    check("sweep_dbz", 32'(div_by_zero), 0);
                end else begin
                    check_result("sweep_z", 255, 0, 1);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
